// File: rtl/mem_stream_demux.sv
// mem_stream_demux: routes a word stream to NDEST double-paged memories.
// Each accepted word is written one cycle later to the selected memory at
// {page, cnt[sel]}. A start pulse flips the page and clears the counters.
// Ports:
//   clk, reset_n            clock, synchronous active-low reset
//   start                   one-cycle event-boundary pulse
//   sel, stream_dat/valid   incoming word and its destination index
//   wr_en/wr_addr/wr_dat    registered one-hot write port to the memories
//   cnt_sel/cnt_out         registered readback of a destination's count
//   ovf, bad_sel            sticky overflow / illegal-destination flags
module mem_stream_demux #(
  parameter int unsigned DATA_W = 12,
  parameter int unsigned NDEST  = 24,
  parameter int unsigned ADDR_W = 6
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  input  logic [4:0]        sel,
  input  logic [DATA_W-1:0] stream_dat,
  input  logic              stream_valid,
  output logic [NDEST-1:0]  wr_en,
  output logic [ADDR_W:0]   wr_addr,
  output logic [DATA_W-1:0] wr_dat,
  input  logic [4:0]        cnt_sel,
  output logic [ADDR_W:0]   cnt_out,
  output logic [NDEST-1:0]  ovf,
  output logic              bad_sel
);

  localparam int unsigned CW    = ADDR_W + 1;
  localparam int unsigned DEPTH = 1 << ADDR_W;
  localparam int unsigned IDX_W = (NDEST > 1) ? $clog2(NDEST) : 1;

  typedef enum logic {IDLE, RUN} state_t;

  state_t          state;
  logic            page;
  logic [CW-1:0]   cnt [NDEST];

  logic            active;
  logic            sel_ok;
  logic            rd_ok;
  logic [IDX_W-1:0] sel_idx;
  logic [IDX_W-1:0] rd_idx;
  logic [CW-1:0]   cur_cnt;
  logic            accept;
  logic            overflow;
  logic            bad;
  logic            page_nxt;
  logic [CW-1:0]   cnt_rd;

  // Accept decode; start is applied before the coincident word, so the
  // word sees the new page and a cleared counter.
  always_comb begin
    active   = stream_valid & ((state == RUN) | start);
    sel_ok   = 32'(sel) < 32'(NDEST);
    sel_idx  = sel_ok ? IDX_W'(sel) : '0;
    cur_cnt  = start ? '0 : cnt[sel_idx];
    accept   = active & sel_ok & (cur_cnt != CW'(DEPTH));
    overflow = active & sel_ok & (cur_cnt == CW'(DEPTH));
    bad      = active & ~sel_ok;
    page_nxt = start ? ~page : page;
    rd_ok    = 32'(cnt_sel) < 32'(NDEST);
    rd_idx   = rd_ok ? IDX_W'(cnt_sel) : '0;
    cnt_rd   = rd_ok ? cnt[rd_idx] : '0;
  end

  // State, counters, flags and the registered write port.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state   <= IDLE;
      page    <= 1'b1;
      wr_en   <= '0;
      wr_addr <= '0;
      wr_dat  <= '0;
      cnt_out <= '0;
      ovf     <= '0;
      bad_sel <= 1'b0;
      for (int unsigned d = 0; d < NDEST; d++) cnt[d] <= '0;
    end else begin
      if (start) state <= RUN;
      page    <= page_nxt;
      cnt_out <= cnt_rd;
      wr_en   <= accept ? (NDEST'(1) << sel_idx) : '0;
      if (accept) begin
        wr_addr <= {page_nxt, cur_cnt[ADDR_W-1:0]};
        wr_dat  <= stream_dat;
      end
      if (start) begin
        ovf <= '0;
        for (int unsigned d = 0; d < NDEST; d++) cnt[d] <= '0;
      end
      // Later assignments override the start clear for the coincident word.
      if (accept)   cnt[sel_idx] <= cur_cnt + CW'(1);
      if (overflow) ovf[sel_idx] <= 1'b1;
      if (bad)      bad_sel <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mem_stream_demux.sv
// Directed self-checking bench for mem_stream_demux (default parameters).
module tb_mem_stream_demux;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [4:0]  sel;
  logic [11:0] stream_dat;
  logic        stream_valid;
  logic [23:0] wr_en;
  logic [6:0]  wr_addr;
  logic [11:0] wr_dat;
  logic [4:0]  cnt_sel;
  logic [6:0]  cnt_out;
  logic [23:0] ovf;
  logic        bad_sel;

  int checks   = 0;
  int failures = 0;

  mem_stream_demux dut (
    .clk(clk), .reset_n(reset_n), .start(start), .sel(sel),
    .stream_dat(stream_dat), .stream_valid(stream_valid),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_dat(wr_dat),
    .cnt_sel(cnt_sel), .cnt_out(cnt_out), .ovf(ovf), .bad_sel(bad_sel)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic word(input logic [4:0] s, input logic [11:0] d);
    stream_valid = 1'b1;
    sel          = s;
    stream_dat   = d;
    tick();
  endtask

  task automatic read_cnt(input logic [4:0] s);
    stream_valid = 1'b0;
    start        = 1'b0;
    cnt_sel      = s;
    tick();
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; sel = '0; stream_dat = '0;
    stream_valid = 1'b0; cnt_sel = '0;
    tick(); tick();
    chk("rst_wr_en", 32'(wr_en), 0);
    chk("rst_wr_addr", 32'(wr_addr), 0);
    chk("rst_wr_dat", 32'(wr_dat), 0);
    chk("rst_cnt_out", 32'(cnt_out), 0);
    chk("rst_ovf", 32'(ovf), 0);
    chk("rst_bad_sel", 32'(bad_sel), 0);

    // Words in IDLE are dropped
    reset_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      word(5'd3, 12'hABC);
      chk("idle_wr_en", 32'(wr_en), 0);
    end
    word(5'd24, 12'h001);
    chk("idle_bad_sel", 32'(bad_sel), 0);
    read_cnt(5'd3);
    chk("idle_cnt3", 32'(cnt_out), 0);

    // First start: page 0
    start = 1'b1; tick(); start = 1'b0;
    chk("start_only_wr_en", 32'(wr_en), 0);
    word(5'd0, 12'h111);
    chk("w0_en", 32'(wr_en), 32'h1);
    chk("w0_addr", 32'(wr_addr), 32'h00);
    chk("w0_dat", 32'(wr_dat), 32'h111);
    word(5'd5, 12'h222);
    chk("w1_en", 32'(wr_en), 32'h20);
    chk("w1_addr", 32'(wr_addr), 32'h00);
    word(5'd0, 12'h333);
    chk("w2_en", 32'(wr_en), 32'h1);
    chk("w2_addr", 32'(wr_addr), 32'h01);
    read_cnt(5'd0);
    chk("hold_en", 32'(wr_en), 0);
    chk("hold_addr", 32'(wr_addr), 32'h01);
    chk("hold_dat", 32'(wr_dat), 32'h333);
    chk("cnt0", 32'(cnt_out), 2);
    read_cnt(5'd5);
    chk("cnt5", 32'(cnt_out), 1);
    read_cnt(5'd30);
    chk("cnt_oob", 32'(cnt_out), 0);

    // Fill destination 23 and overflow it
    for (int i = 0; i < 65; i++) begin
      word(5'd23, 12'(i + 12'h100));
      if (i < 64) begin
        chk("fill_en", 32'(wr_en), 32'h80_0000);
        chk("fill_addr", 32'(wr_addr), 32'(i));
        chk("fill_dat", 32'(wr_dat), 32'(i + 'h100));
        if (i == 63) chk("fill_no_ovf", 32'(ovf), 0);
      end else begin
        chk("ovf_en", 32'(wr_en), 0);
        chk("ovf_addr_hold", 32'(wr_addr), 32'h3F);
        chk("ovf_flag", 32'(ovf), 32'h80_0000);
      end
    end
    read_cnt(5'd23);
    chk("cnt23_full", 32'(cnt_out), 64);

    // Illegal destinations in RUN
    word(5'd24, 12'h0AA);
    chk("bad24_en", 32'(wr_en), 0);
    chk("bad24_flag", 32'(bad_sel), 1);
    word(5'd31, 12'h0BB);
    chk("bad31_en", 32'(wr_en), 0);
    read_cnt(5'd0);
    chk("bad_cnt0_kept", 32'(cnt_out), 2);

    // Second start coincident with a word: page 1, entry 0
    start = 1'b1; word(5'd2, 12'h123); start = 1'b0;
    chk("s2_en", 32'(wr_en), 32'h4);
    chk("s2_addr", 32'(wr_addr), 32'h40);
    chk("s2_dat", 32'(wr_dat), 32'h123);
    chk("s2_ovf_clr", 32'(ovf), 0);
    chk("s2_bad_kept", 32'(bad_sel), 1);
    read_cnt(5'd23);
    chk("s2_cnt23", 32'(cnt_out), 0);
    read_cnt(5'd2);
    chk("s2_cnt2", 32'(cnt_out), 1);
    word(5'd2, 12'h124);
    chk("s2_next_addr", 32'(wr_addr), 32'h41);

    // Third start flips back to page 0
    start = 1'b1; word(5'd7, 12'h0F0); start = 1'b0;
    chk("s3_en", 32'(wr_en), 32'h80);
    chk("s3_addr", 32'(wr_addr), 32'h00);

    // Reset right after an accepted word
    word(5'd4, 12'h444);
    chk("pre_rst_en", 32'(wr_en), 32'h10);
    reset_n = 1'b0; word(5'd4, 12'h555);
    chk("abort_en", 32'(wr_en), 0);
    chk("abort_addr", 32'(wr_addr), 0);
    chk("abort_ovf", 32'(ovf), 0);
    chk("abort_bad", 32'(bad_sel), 0);
    reset_n = 1'b1; word(5'd4, 12'h666);
    chk("post_rst_drop", 32'(wr_en), 0);
    read_cnt(5'd4);
    chk("post_rst_cnt4", 32'(cnt_out), 0);
    read_cnt(5'd7);
    chk("post_rst_cnt7", 32'(cnt_out), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
